// File: rtl/ram_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_bridge_pkg
// Purpose  : Shared types and constants for the ram_bridge block.
//            - FSM state encoding
//            - Access size codes
//            - Default RAM base address (PC_START)
//            - Lane-mask helper functions
// Revision : 1.0 - initial release
// ============================================================================
package ram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  // Byte address that maps to RAM word index 0 by default.
  localparam logic [63:0] PC_START = 64'h0000_0000_8000_0000;

  // Right-aligned bit mask covering 2^size bytes.
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      SZ_BYTE: m = 64'h0000_0000_0000_00FF;
      SZ_HALF: m = 64'h0000_0000_0000_FFFF;
      SZ_WORD: m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  // True when the byte offset is not a multiple of the access size.
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    logic [2:0] low;
    case (size)
      SZ_BYTE: low = 3'b000;
      SZ_HALF: low = 3'b001;
      SZ_WORD: low = 3'b011;
      default: low = 3'b111;
    endcase
    return (off & low) != 3'b000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_bridge_arb.sv
`default_nettype none
// ============================================================================
// Module   : ram_bridge_arb
// Purpose  : Request-to-one-hot grant for the ram_bridge channels.
//            RAM_BRIDGE_RR_EN defined  : round-robin.
//              - The search starts at r_ptr.
//              - r_ptr moves to granted+1 on every accepted grant.
//            RAM_BRIDGE_RR_EN undefined: fixed priority, lowest index wins.
// Ports    : clk, rst_n      - clock, async active-low reset (RR pointer only)
//            i_req           - per-channel request
//            i_take          - grant accepted this cycle (advances pointer)
//            o_gnt           - one-hot grant
//            o_gnt_idx       - binary index of the granted channel
//            o_any           - at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module ram_bridge_arb
  import ram_bridge_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_take,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [1:0]        o_gnt_idx,
  output logic              o_any
);

`ifdef RAM_BRIDGE_RR_EN
  logic [1:0] r_ptr;

  // Search order is r_ptr, r_ptr+1, ... modulo NUM_CH; first requester wins.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = 2'd0;
    o_any     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!o_any && i_req[k] && (((int'(r_ptr) + i) % NUM_CH) == k)) begin
          o_any     = 1'b1;
          o_gnt[k]  = 1'b1;
          o_gnt_idx = 2'(k);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 2'd0;
    end else if (i_take) begin
      r_ptr <= (o_gnt_idx == 2'(NUM_CH - 1)) ? 2'd0 : o_gnt_idx + 2'd1;
    end
  end
`else
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = 2'd0;
    o_any     = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!o_any && i_req[k]) begin
        o_any     = 1'b1;
        o_gnt[k]  = 1'b1;
        o_gnt_idx = 2'(k);
      end
    end
  end

  // Fixed priority is stateless; clock, reset and take are not needed.
  logic w_unused_arb;
  assign w_unused_arb = ^{clk, rst_n, i_take};
`endif

endmodule
`default_nettype wire

// File: rtl/ram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ram_bridge
// Purpose  : Arbitrates NUM_CH ram_rw requesters onto one single-port RAM.
//            - Byte address -> 64-bit word index relative to BASE_ADDR.
//            - Sub-word lane shifting and write masks.
//            - One-cycle ready pulse LAT cycles after the RAM access.
//            Macro RAM_BRIDGE_RR_EN selects round-robin arbitration.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            ch_cen_i/ch_wen_i          - per-channel request / write select
//            ch_addr_i/ch_wdata_i       - per-channel 64-bit address / data
//            ch_size_i                  - per-channel 3-bit size code
//            ch_ready_o/ch_err_o        - completion pulse / misalign flag
//            ch_rdata_o                 - right-aligned read data
//            ram_en_o/ram_wen_o         - RAM strobe / write enable
//            ram_idx_o                  - RAM word index
//            ram_wdata_o/ram_wmask_o    - lane-shifted data / bit mask
//            ram_rdata_i                - RAM read data (same cycle)
// Revision : 1.0 - initial release
// ============================================================================
module ram_bridge
  import ram_bridge_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter logic [63:0] BASE_ADDR = PC_START,
  parameter int          LAT       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    ch_cen_i,
  input  logic [NUM_CH-1:0]    ch_wen_i,
  input  logic [NUM_CH*64-1:0] ch_addr_i,
  input  logic [NUM_CH*64-1:0] ch_wdata_i,
  input  logic [NUM_CH*3-1:0]  ch_size_i,
  output logic [NUM_CH-1:0]    ch_ready_o,
  output logic [NUM_CH-1:0]    ch_err_o,
  output logic [NUM_CH*64-1:0] ch_rdata_o,
  output logic                 ram_en_o,
  output logic                 ram_wen_o,
  output logic [63:0]          ram_idx_o,
  output logic [63:0]          ram_wdata_o,
  output logic [63:0]          ram_wmask_o,
  input  logic [63:0]          ram_rdata_i
);

  // BUSY lasts LAT-1 cycles; the counter exits BUSY when it reaches 0.
  localparam logic [3:0] C_CNT_INIT = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

  state_e      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_ch;
  logic [1:0]  r_size;
  logic [2:0]  r_off;
  logic        r_err;
  logic [63:0] r_rdata_q;

  logic [NUM_CH-1:0] w_gnt;
  logic [1:0]        w_gnt_idx;
  logic              w_any;
  logic              w_take;
  logic              w_access;
  logic              w_wr;
  logic              w_mis;
  logic [63:0]       w_sel_addr;
  logic [63:0]       w_sel_wdata;
  logic [2:0]        w_sel_size;
  logic              w_sel_wen;
  logic [2:0]        w_off;
  logic [5:0]        w_shamt;
  logic [63:0]       w_rd;
  logic              w_unused_size;

  ram_bridge_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (ch_cen_i),
    .i_take    (w_take),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  // Route the granted channel's request fields.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_size  = '0;
    w_sel_wen   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_gnt[k]) begin
        w_sel_addr  = ch_addr_i[k*64 +: 64];
        w_sel_wdata = ch_wdata_i[k*64 +: 64];
        w_sel_size  = ch_size_i[k*3 +: 3];
        w_sel_wen   = ch_wen_i[k];
      end
    end
  end

  // Only codes 0..3 exist; the top size bit carries no information.
  assign w_unused_size = w_sel_size[2];

  assign w_off   = w_sel_addr[2:0];
  assign w_shamt = {w_off, 3'b000};
  assign w_mis   = misaligned(w_off, w_sel_size[1:0]);

  // rst_n gates the grant so that RAM outputs drop at once on async reset,
  // even while a requester still holds cen.
  assign w_take   = (r_state == ST_IDLE) && w_any && rst_n;
  assign w_access = w_take && !w_mis;
  assign w_wr     = w_access && w_sel_wen;

  assign ram_en_o    = w_access;
  assign ram_wen_o   = w_wr;
  assign ram_idx_o   = w_access ? ((w_sel_addr - BASE_ADDR) >> 3) : 64'd0;
  assign ram_wdata_o = w_wr ? (w_sel_wdata << w_shamt) : 64'd0;
  assign ram_wmask_o = w_wr ? (size_mask(w_sel_size[1:0]) << w_shamt) : 64'd0;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_take) begin
          if (LAT > 1) begin
            w_state_nxt = ST_BUSY;
            w_cnt_nxt   = C_CNT_INIT;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_ch      <= 2'd0;
      r_size    <= 2'd0;
      r_off     <= 3'd0;
      r_err     <= 1'b0;
      r_rdata_q <= 64'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_take) begin
        r_ch      <= w_gnt_idx;
        r_size    <= w_sel_size[1:0];
        r_off     <= w_off;
        r_err     <= w_mis;
        // Misaligned accesses and writes return zero data.
        r_rdata_q <= (w_access && !w_sel_wen) ? ram_rdata_i : 64'd0;
      end
    end
  end

  assign w_rd = (r_rdata_q >> {r_off, 3'b000}) & size_mask(r_size);

  always_comb begin
    ch_ready_o = '0;
    ch_err_o   = '0;
    ch_rdata_o = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if ((r_state == ST_DONE) && (r_ch == 2'(k))) begin
        ch_ready_o[k]          = 1'b1;
        ch_err_o[k]            = r_err;
        ch_rdata_o[k*64 +: 64] = w_rd;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_bridge
// Purpose  : Self-checking bench for ram_bridge.
//            - DUT A: NUM_CH=2, LAT=1.
//            - DUT B: NUM_CH=2, LAT=4.
//            - Expected completions are queued at issue time and checked by
//              a monitor whenever a ready pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ram_bridge;

  typedef struct {
    int          ch;
    logic        err;
    logic [63:0] rdata;
    bit          chk_rd;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0]   a_cen, a_wen, a_ready, a_err;
  logic [127:0] a_addr, a_wdata, a_rdata;
  logic [5:0]   a_size;
  logic         a_en, a_ramwen;
  logic [63:0]  a_idx, a_ramwdata, a_wmask, a_ramrdata;

  logic [1:0]   b_cen, b_wen, b_ready, b_err;
  logic [127:0] b_addr, b_wdata, b_rdata;
  logic [5:0]   b_size;
  logic         b_en, b_ramwen;
  logic [63:0]  b_idx, b_ramwdata, b_wmask, b_ramrdata;

  logic [63:0] mem_a [16];
  logic [63:0] mem_b [16];

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  ram_bridge #(.NUM_CH(2), .BASE_ADDR(64'h8000_0000), .LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .ch_cen_i(a_cen), .ch_wen_i(a_wen), .ch_addr_i(a_addr), .ch_wdata_i(a_wdata),
    .ch_size_i(a_size), .ch_ready_o(a_ready), .ch_err_o(a_err), .ch_rdata_o(a_rdata),
    .ram_en_o(a_en), .ram_wen_o(a_ramwen), .ram_idx_o(a_idx),
    .ram_wdata_o(a_ramwdata), .ram_wmask_o(a_wmask), .ram_rdata_i(a_ramrdata)
  );

  ram_bridge #(.NUM_CH(2), .BASE_ADDR(64'h8000_0000), .LAT(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .ch_cen_i(b_cen), .ch_wen_i(b_wen), .ch_addr_i(b_addr), .ch_wdata_i(b_wdata),
    .ch_size_i(b_size), .ch_ready_o(b_ready), .ch_err_o(b_err), .ch_rdata_o(b_rdata),
    .ram_en_o(b_en), .ram_wen_o(b_ramwen), .ram_idx_o(b_idx),
    .ram_wdata_o(b_ramwdata), .ram_wmask_o(b_wmask), .ram_rdata_i(b_ramrdata)
  );

  // Behavioural single-port RAMs: combinational read, masked write.
  assign a_ramrdata = a_en ? mem_a[a_idx[3:0]] : 64'd0;
  assign b_ramrdata = b_en ? mem_b[b_idx[3:0]] : 64'd0;
  always @(posedge clk) begin
    if (a_en && a_ramwen)
      mem_a[a_idx[3:0]] <= (mem_a[a_idx[3:0]] & ~a_wmask) | (a_ramwdata & a_wmask);
    if (b_en && b_ramwen)
      mem_b[b_idx[3:0]] <= (mem_b[b_idx[3:0]] & ~b_wmask) | (b_ramwdata & b_wmask);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop one expectation per ready pulse.
  task automatic mon(input int dut, input logic [1:0] rdy, input logic [1:0] err,
                     input logic [127:0] rd);
    exp_t e;
    bit   empty;
    for (int k = 0; k < 2; k++) begin
      if (rdy[k]) begin
        empty = (dut == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
        if (empty) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ready dut%0d ch%0d: got ready, required none (cycle %0d)",
                   dut, k, cyc);
        end else begin
          if (dut == 0) e = q_a.pop_front();
          else          e = q_b.pop_front();
          chk($sformatf("ready_ch_dut%0d", dut), 64'(k), 64'(e.ch));
          chk($sformatf("ready_cycle_dut%0d", dut), 64'(cyc), 64'(e.cyc));
          chk($sformatf("err_dut%0d", dut), 64'(err[k]), 64'(e.err));
          if (e.chk_rd) chk($sformatf("rdata_dut%0d", dut), rd[k*64 +: 64], e.rdata);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_ready, a_err, a_rdata);
    mon(1, b_ready, b_err, b_rdata);
  end

  task automatic drive(input int dut, input int ch, input logic wen, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [2:0] size);
    if (dut == 0) begin
      a_cen[ch] = 1'b1; a_wen[ch] = wen; a_addr[ch*64 +: 64] = addr;
      a_wdata[ch*64 +: 64] = wdata; a_size[ch*3 +: 3] = size;
    end else begin
      b_cen[ch] = 1'b1; b_wen[ch] = wen; b_addr[ch*64 +: 64] = addr;
      b_wdata[ch*64 +: 64] = wdata; b_size[ch*3 +: 3] = size;
    end
  endtask

  task automatic push(input int dut, input int ch, input logic err, input logic [63:0] rd,
                      input bit chk_rd, input int lat);
    exp_t e;
    e.ch = ch; e.err = err; e.rdata = rd; e.chk_rd = chk_rd; e.cyc = cyc + lat;
    if (dut == 0) q_a.push_back(e);
    else          q_b.push_back(e);
  endtask

  task automatic ram_chk(input int dut, input logic en, input logic wen, input logic [63:0] idx,
                         input logic [63:0] wd, input logic [63:0] wm);
    if (dut == 0) begin
      chk("ram_en_a", 64'(a_en), 64'(en));       chk("ram_wen_a", 64'(a_ramwen), 64'(wen));
      chk("ram_idx_a", a_idx, idx);              chk("ram_wdata_a", a_ramwdata, wd);
      chk("ram_wmask_a", a_wmask, wm);
    end else begin
      chk("ram_en_b", 64'(b_en), 64'(en));       chk("ram_wen_b", 64'(b_ramwen), 64'(wen));
      chk("ram_idx_b", b_idx, idx);              chk("ram_wdata_b", b_ramwdata, wd);
      chk("ram_wmask_b", b_wmask, wm);
    end
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_ready"}, {60'd0, a_ready, b_ready}, 64'd0);
    chk({tag, "_err"}, {60'd0, a_err, b_err}, 64'd0);
    chk({tag, "_rdata"}, a_rdata[63:0] | a_rdata[127:64] | b_rdata[63:0] | b_rdata[127:64], 64'd0);
    chk({tag, "_ram_en"}, {62'd0, a_en, b_en}, 64'd0);
    chk({tag, "_ram_wen"}, {62'd0, a_ramwen, b_ramwen}, 64'd0);
    chk({tag, "_ram_idx"}, a_idx | b_idx, 64'd0);
    chk({tag, "_ram_wdata"}, a_ramwdata | b_ramwdata, 64'd0);
    chk({tag, "_ram_wmask"}, a_wmask | b_wmask, 64'd0);
  endtask

  // One complete request: issue, check RAM side, queue expectation,
  // wait for ready (bounded), confirm no new grant in the ready cycle.
  task automatic txn(input int dut, input int ch, input logic wen, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [2:0] size,
                     input logic x_en, input logic [63:0] x_idx, input logic [63:0] x_wd,
                     input logic [63:0] x_wm, input logic x_err, input logic [63:0] x_rd,
                     input bit chk_rd, input int lat);
    bit seen;
    @(negedge clk);
    drive(dut, ch, wen, addr, wdata, size);
    #1;
    ram_chk(dut, x_en, x_en & wen, x_idx, x_wd, x_wm);
    push(dut, ch, x_err, x_rd, chk_rd, lat);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (dut == 0) ? a_ready[ch] : b_ready[ch];
    end
    chk("ready_seen", 64'(seen), 64'd1);
    chk("no_grant_in_done", 64'((dut == 0) ? a_en : b_en), 64'd0);
    if (dut == 0) a_cen[ch] = 1'b0;
    else          b_cen[ch] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit any_rdy;
    rst_n = 1'b0;
    a_cen = '0; a_wen = '0; a_addr = '0; a_wdata = '0; a_size = '0;
    b_cen = '0; b_wen = '0; b_addr = '0; b_wdata = '0; b_size = '0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 64'h5555_5555_5555_5555;
      mem_b[i] = 64'h5555_5555_5555_5555;
    end
    mem_a[0]  = 64'd0;
    mem_a[2]  = 64'h1122_3344_5566_7788;
    mem_a[3]  = 64'hA5A5_0000_DEAD_BEEF;
    mem_a[4]  = 64'h0123_4567_89AB_CDEF;
    mem_b[2]  = 64'h1122_3344_5566_7788;
    mem_b[15] = 64'h0F0E_0D0C_0B0A_0908;

    repeat (3) @(negedge clk);
    outs_zero("reset");
    rst_n = 1'b1;

    // Dword read, LAT=1
    txn(0, 0, 1'b0, 64'h8000_0010, 64'd0, 3'd3, 1'b1, 64'd2, 64'd0, 64'd0,
        1'b0, 64'h1122_3344_5566_7788, 1'b1, 1);
    // Byte write at offset 5
    txn(0, 1, 1'b1, 64'h8000_0005, 64'hAB, 3'd0, 1'b1, 64'd0,
        64'h0000_AB00_0000_0000, 64'h0000_FF00_0000_0000, 1'b0, 64'd0, 1'b0, 1);
    // Byte read-back and half read at offset 4
    txn(0, 1, 1'b0, 64'h8000_0005, 64'd0, 3'd0, 1'b1, 64'd0, 64'd0, 64'd0,
        1'b0, 64'hAB, 1'b1, 1);
    txn(0, 0, 1'b0, 64'h8000_0004, 64'd0, 3'd1, 1'b1, 64'd0, 64'd0, 64'd0,
        1'b0, 64'hAB00, 1'b1, 1);
    // Misaligned half read at offset 7
    txn(0, 0, 1'b0, 64'h8000_0017, 64'd0, 3'd1, 1'b0, 64'd0, 64'd0, 64'd0,
        1'b1, 64'd0, 1'b1, 1);
    // Word write into low lane, then dword read-back shows merged bytes
    txn(0, 0, 1'b1, 64'h8000_0008, 64'hCAFE_F00D, 3'd2, 1'b1, 64'd1,
        64'h0000_0000_CAFE_F00D, 64'h0000_0000_FFFF_FFFF, 1'b0, 64'd0, 1'b0, 1);
    txn(0, 1, 1'b0, 64'h8000_0008, 64'd0, 3'd3, 1'b1, 64'd1, 64'd0, 64'd0,
        1'b0, 64'h5555_5555_CAFE_F00D, 1'b1, 1);

    // Contention: both channels held for four grants
    @(negedge clk);
    drive(0, 0, 1'b0, 64'h8000_0018, 64'd0, 3'd3);
    drive(0, 1, 1'b0, 64'h8000_0020, 64'd0, 3'd3);
    #1;
    ram_chk(0, 1'b1, 1'b0, 64'd3, 64'd0, 64'd0);
    push(0, 0, 1'b0, 64'hA5A5_0000_DEAD_BEEF, 1'b1, 1);
`ifdef RAM_BRIDGE_RR_EN
    push(0, 1, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, 3);
    push(0, 0, 1'b0, 64'hA5A5_0000_DEAD_BEEF, 1'b1, 5);
    push(0, 1, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, 7);
`else
    push(0, 0, 1'b0, 64'hA5A5_0000_DEAD_BEEF, 1'b1, 3);
    push(0, 0, 1'b0, 64'hA5A5_0000_DEAD_BEEF, 1'b1, 5);
    push(0, 0, 1'b0, 64'hA5A5_0000_DEAD_BEEF, 1'b1, 7);
`endif
    repeat (7) @(negedge clk);
    a_cen = 2'b00;

    // LAT=4: word read at offset 4, then a below-base dword read
    txn(1, 0, 1'b0, 64'h8000_0014, 64'd0, 3'd2, 1'b1, 64'd2, 64'd0, 64'd0,
        1'b0, 64'h1122_3344, 1'b1, 4);
    txn(1, 1, 1'b0, 64'h7FFF_FFF8, 64'd0, 3'd3, 1'b1, 64'h1FFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,
        1'b0, 64'h0F0E_0D0C_0B0A_0908, 1'b1, 4);

    // Reset in cycle 2 of a LAT=4 transaction
    @(negedge clk);
    drive(1, 0, 1'b0, 64'h8000_0010, 64'd0, 3'd3);
    #1;
    ram_chk(1, 1'b1, 1'b0, 64'd2, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    outs_zero("midreset");
    any_rdy = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_rdy = any_rdy | (|b_ready);
    end
    chk("no_ready_during_reset", 64'(any_rdy), 64'd0);
    rst_n = 1'b1;
    #1;
    ram_chk(1, 1'b1, 1'b0, 64'd2, 64'd0, 64'd0);
    push(1, 0, 1'b0, 64'h1122_3344_5566_7788, 1'b1, 4);
    any_rdy = 1'b0;
    for (int i = 0; i < 40 && !any_rdy; i++) begin
      @(negedge clk);
      any_rdy = b_ready[0];
    end
    chk("ready_after_reset", 64'(any_rdy), 64'd1);
    b_cen = 2'b00;

    repeat (4) @(negedge clk);
    chk("queue_a_empty", 64'(q_a.size()), 64'd0);
    chk("queue_b_empty", 64'(q_b.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_bridge.md
# ram_bridge

Parametrised multi-channel bridge between the core's `ram_rw_*` request interfaces and the single-port `RAMHelper` simulation memory in the simulation top. It arbitrates `NUM_CH` requesters, such as instruction fetch and load/store, onto one RAM port. It translates byte addresses to 64-bit word indices relative to `BASE_ADDR` and generates sub-word write masks from the access size. It returns the result through a `ready` pulse after a configurable latency `LAT`.

## Interface
Parameters:
- `NUM_CH`, default 2: number of requesting channels (1..4).
- `BASE_ADDR`, default `` `PC_START ``: byte address that maps to RAM index 0.
- `LAT`, default 1: cycles from RAM access to `ready` (1..15).

Ports:
- `clk` in 1: clock. One clock domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `ch_cen_i` in NUM_CH: per-channel request, held until that channel's `ready`.
- `ch_wen_i` in NUM_CH: 1 = write, 0 = read.
- `ch_addr_i` in NUM_CH*64: byte address; channel k occupies bits [64k+63:64k].
- `ch_wdata_i` in NUM_CH*64: write data, right-aligned.
- `ch_size_i` in NUM_CH*3: size code; 0 = byte, 1 = half, 2 = word, 3 = dword.
- `ch_ready_o` out NUM_CH: one-cycle completion pulse.
- `ch_err_o` out NUM_CH: misalignment flag, valid only with `ready`.
- `ch_rdata_o` out NUM_CH*64: read data, right-aligned and zero-extended, valid with `ready`.
- `ram_en_o` out 1: RAM access strobe.
- `ram_wen_o` out 1: RAM write enable.
- `ram_idx_o` out 64: word index, equal to (addr − BASE_ADDR) >> 3.
- `ram_wdata_o` out 64: lane-shifted write data.
- `ram_wmask_o` out 64: bit mask of the written bytes.
- `ram_rdata_i` in 64: RAM read data, valid combinationally in the cycle `ram_en_o` is high.

## Operation
- FSM states:
  - IDLE: arbitrate; on grant, drive the RAM strobe combinationally in the same cycle.
  - BUSY: count LAT−1 cycles.
  - DONE: pulse `ready` to the granted channel.
- Transitions:
  - IDLE→DONE when LAT=1.
  - IDLE→BUSY when LAT>1; BUSY→DONE when the counter reaches 0.
  - DONE→IDLE unconditionally.
  - No grant is made in DONE, so a still-high `cen` is never double-served.
- Grant latch: the channel index and size/offset are latched at the IDLE grant. Read data is captured into `rdata_q` in the grant cycle.
- Lane handling:
  - off = addr[2:0].
  - `ram_wdata_o` = wdata << (8·off).
  - `ram_wmask_o` = {8·2^size ones} << (8·off).
  - `ch_rdata_o` = (rdata_q >> 8·off) masked to 2^size bytes.
- Misalignment: if off mod 2^size ≠ 0, no RAM strobe is issued. The FSM still traverses BUSY/DONE and asserts `ch_err_o` with `ready`. Read data is 0 in this case.
- Address below BASE_ADDR: the index wraps modulo 2^64. There is no check; this is the caller's responsibility.
- RAM outputs are 0 whenever `ram_en_o` = 0.

## Timing
- Request sampled in cycle 0 (IDLE) → `ram_en_o` in cycle 0 → `ready` in cycle LAT.
- Minimum issue interval per request is LAT+1 cycles.
- A channel that drops `cen` before `ready` is still completed; `ready` pulses and the result is discarded by the requester.
- Requests arriving during BUSY or DONE wait for IDLE.
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Counter 0.
  - `rdata_q` 0.
  - Round-robin pointer 0.
- Reset asserted mid-BUSY aborts the transaction with no `ready` pulse.

## Configuration
- `RAM_BRIDGE_RR_EN` defined:
  - Round-robin arbitration.
  - The pointer advances to granted+1 on each grant; the search starts at the pointer.
- `RAM_BRIDGE_RR_EN` undefined:
  - Fixed priority, lowest index wins.
  - No pointer register.

## Structure
- `defines.v` holds:
  - FSM state encodings: IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2.
  - Size codes.
  - `` `PC_START `` for `BASE_ADDR`.
- One sub-module, `ram_bridge_arb`:
  - Combinational request-to-one-hot grant, plus the optional round-robin pointer register.
  - The FSM, lane shifting and counter remain in `ram_bridge`.

## Test plan
- Dword read, LAT=1:
  - Stimulus: ch0 read at 0x8000_0010; `ram_rdata_i` = 0x1122334455667788.
  - Required: `ram_idx_o` = 2 in cycle 0; `ch_ready_o[0]` in cycle 1 with that data; next grant no earlier than cycle 2.
- Byte write:
  - Stimulus: ch1 write at 0x8000_0005, size 0, wdata 0xAB.
  - Required: `ram_wmask_o` = 0x0000_FF00_0000_0000; `ram_wdata_o` = 0x0000_AB00_0000_0000.
- Contention (round-robin built):
  - Stimulus: ch0 and ch1 `cen` held continuously.
  - Required: grant order ch0, ch1, ch0, ch1.
  - Without the macro: ch0 is always granted.
- Misaligned half read:
  - Stimulus: half read at offset 7.
  - Required: no `ram_en_o`; `ready` and `err` asserted in cycle 1; rdata 0.
- LAT=4:
  - Stimulus: a word read at offset 4.
  - Required: `ready` exactly in cycle 4; `ch_rdata_o` = bits [63:32] of the RAM word.
- Reset mid-transaction:
  - Stimulus: with LAT=4, assert `rst_n` low in cycle 2.
  - Required: all outputs go to 0 immediately; no `ready` pulse; after release, a new request is served normally.
